// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers.
package pipe_pkg;

    // Packed payload widths of each inter-stage bus.
    localparam int IFID_W  = 64;   // PCPlus4 + Instruction
    localparam int IDEX_W  = 160;
    localparam int EXMEM_W = 110;
    localparam int MEMWB_W = 72;

    // Fill bit for a bubble; an empty entry always holds all-BUBBLE data.
    localparam logic BUBBLE = 1'b0;

    // Encodings of the occupancy output.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_entry.sv
// One valid+data register. Clearing zeroes the data so an invalid entry
// always reads as a bubble.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = IFID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Reset and clear win over load; a cleared entry holds a bubble.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            data  <= {DATA_W{BUBBLE}};
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready on both sides, optional skid
// entry so in_ready is a flop, flush with bubble insertion and a saturating
// count of flushed entries.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W           = IFID_W,
    parameter int SKID             = 1,
    parameter int FLUSH_OVER_STALL = 1,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  dropped_cnt
);

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic              skid_v;
    logic              take;
    logic              fire;
    logic              flush_eff;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_ld_data;
    logic              main_v_next;
    logic              skid_v_next;
    logic [CNT_W:0]    cnt_sum;
    occ_e              occ_q;

    assign take      = main_v & out_ready & ~stall;
    assign fire      = in_valid & in_ready;
    assign flush_eff = flush & ((FLUSH_OVER_STALL != 0) | ~stall);

    pipe_entry #(.DATA_W(DATA_W)) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .clear     (main_clear),
        .load_data (main_ld_data),
        .valid     (main_v),
        .data      (main_d)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_load;
            logic              skid_clear;
            logic              ready_q;
            logic [DATA_W-1:0] skid_d;

            // Main refills from skid when it drains while full; otherwise
            // it takes the new payload when empty or draining.
            assign main_load    = ~flush_eff & ((skid_v & take) |
                                                (~skid_v & fire & (~main_v | take)));
            assign main_ld_data = skid_v ? skid_d : in_data;
            assign main_clear   = flush_eff | (take & ~skid_v & ~fire);

            // Skid only catches a payload that arrives while main is stuck.
            assign skid_load    = ~flush_eff & fire & main_v & ~take & ~skid_v;
            assign skid_clear   = flush_eff | (skid_v & take);
            assign skid_v_next  = skid_load | (skid_v & ~skid_clear);

            pipe_entry #(.DATA_W(DATA_W)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .load      (skid_load),
                .clear     (skid_clear),
                .load_data (in_data),
                .valid     (skid_v),
                .data      (skid_d)
            );

            // Ready is the registered "skid will be empty" flag, so no
            // downstream signal reaches in_ready combinationally.
            always_ff @(posedge clk) begin
                if (rst) ready_q <= 1'b1;
                else     ready_q <= ~skid_v_next;
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            assign skid_v       = 1'b0;
            assign skid_v_next  = 1'b0;
            assign in_ready     = ~main_v | take;
            assign main_load    = ~flush_eff & fire;
            assign main_ld_data = in_data;
            assign main_clear   = flush_eff | (take & ~fire);
        end
    endgenerate

    assign main_v_next = main_load | (main_v & ~main_clear);

    // Occupancy tracks the next-state entry count as a register.
    always_ff @(posedge clk) begin
        if (rst) occ_q <= OCC_EMPTY;
        else     occ_q <= occ_e'({1'b0, main_v_next} + {1'b0, skid_v_next});
    end

    // One extra bit catches overflow so the counter can saturate.
    assign cnt_sum = {1'b0, dropped_cnt} + {{CNT_W{1'b0}}, main_v} + {{CNT_W{1'b0}}, skid_v};

    // Count entries discarded by an effective flush; the payload arriving
    // in the flush cycle is never stored and so is not counted.
    always_ff @(posedge clk) begin
        if (rst)
            dropped_cnt <= '0;
        else if (flush_eff)
            dropped_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occupancy = occ_q;

endmodule
